// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer
// Conditions the raw CPU_RESET_n pushbutton and releases the system resets in
// order: system PLL, then DDR2LP EMIF, then core logic. Each step waits for PLL
// lock or EMIF calibration. A timeout or a calibration failure triggers a retry.
// When the retries run out, the sequencer parks in FAIL until the button is
// pressed.
//
// Ports:
//   clk              free-running reference clock
//   reset_n          asynchronous active-low reset
//   button_n         raw pushbutton, asynchronous, active-low
//   pll_locked       system PLL lock, asynchronous
//   emif_cal_success EMIF calibration success, asynchronous
//   emif_cal_fail    EMIF calibration failure, asynchronous
//   pll_reset        active-high system PLL reset
//   emif_reset_n     active-low EMIF / memory PLL reset
//   core_reset_n     active-low core logic reset
//   seq_fail         sticky flag: retries exhausted
//   seq_state        current state encoding (debug / LEDs)

module cpu_reset_sequencer #(
    parameter int unsigned SYNC_DEPTH       = 2,
    parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
    parameter int unsigned PLL_RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT     = 65536,
    parameter int unsigned CAL_TIMEOUT      = 4194304,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_n,
    input  logic       pll_locked,
    input  logic       emif_cal_success,
    input  logic       emif_cal_fail,
    output logic       pll_reset,
    output logic       emif_reset_n,
    output logic       core_reset_n,
    output logic       seq_fail,
    output logic [2:0] seq_state
);

    // Counter width for a limit; at least one bit so a limit of 1 still works.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned PR_W   = cnt_width(PLL_RESET_CYCLES);
    localparam int unsigned LT_W   = cnt_width(LOCK_TIMEOUT);
    localparam int unsigned CT_W   = cnt_width(CAL_TIMEOUT);
    localparam int unsigned CNT_W  = (PR_W > LT_W) ? ((PR_W > CT_W) ? PR_W : CT_W)
                                                   : ((LT_W > CT_W) ? LT_W : CT_W);
    localparam int unsigned RT_W   = cnt_width(MAX_RETRIES);
    localparam int unsigned NSYNC  = 4;

    typedef enum logic [2:0] {
        ST_BTN       = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_WAIT_CAL  = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers: all four asynchronous inputs share one shift chain.
    // The chain resets to 1 and is flushed well within PLL_RST.
    // ------------------------------------------------------------------
    logic [SYNC_DEPTH-1:0][NSYNC-1:0] sync_q;
    logic [NSYNC-1:0]                 sync_out;
    logic                             btn_s;
    logic                             lock_s;
    logic                             cal_ok_s;
    logic                             cal_fail_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0],
                       {emif_cal_fail, emif_cal_success, pll_locked, button_n}};
        end
    end

    assign sync_out   = sync_q[SYNC_DEPTH-1];
    assign btn_s      = sync_out[0];
    assign lock_s     = sync_out[1];
    assign cal_ok_s   = sync_out[2];
    assign cal_fail_s = sync_out[3];

    // ------------------------------------------------------------------
    // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive
    // mismatching cycles. db_next feeds the FSM directly so that a press
    // or release acts on the same edge the debounced value flips.
    // ------------------------------------------------------------------
    logic            db_q;
    logic            db_next;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_next;

    always_comb begin
        db_next     = db_q;
        db_cnt_next = '0;
        if (btn_s != db_q) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_next = btn_s;
            end else begin
                db_cnt_next = db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q   <= 1'b1;
            db_cnt <= '0;
        end else begin
            db_q   <= db_next;
            db_cnt <= db_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [RT_W-1:0]  retry;
    logic [RT_W-1:0]  retry_next;
    logic             retry_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_PLL_RST;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            retry <= retry_next;
        end
    end

    // Next-state logic; the button override is applied last so it wins.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        retry_next = retry;
        retry_req  = 1'b0;

        case (state)
            ST_BTN: begin
                if (db_next) begin
                    state_next = ST_PLL_RST;
                    cnt_next   = '0;
                end
            end
            ST_PLL_RST: begin
                if (cnt == CNT_W'(PLL_RESET_CYCLES - 1)) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_WAIT_CAL;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_req = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_CAL: begin
                // Fail is checked before success so a simultaneous pair retries.
                if (!lock_s || cal_fail_s) begin
                    retry_req = 1'b1;
                end else if (cal_ok_s) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                    retry_next = '0;
                end else if (cnt == CNT_W'(CAL_TIMEOUT - 1)) begin
                    retry_req = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss after a good bring-up restarts without using a retry.
                if (!lock_s) begin
                    state_next = ST_PLL_RST;
                    cnt_next   = '0;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_PLL_RST;
                cnt_next   = '0;
            end
        endcase

        // Retry bookkeeping: the last allowed attempt goes to FAIL.
        if (retry_req) begin
            cnt_next = '0;
            if (retry == RT_W'(MAX_RETRIES - 1)) begin
                state_next = ST_FAIL;
            end else begin
                state_next = ST_PLL_RST;
                retry_next = retry + RT_W'(1);
            end
        end

        if (!db_next) begin
            state_next = ST_BTN;
            cnt_next   = '0;
            retry_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs decoded from the next state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_reset    <= 1'b1;
            emif_reset_n <= 1'b0;
            core_reset_n <= 1'b0;
            seq_fail     <= 1'b0;
            seq_state    <= 3'd1;
        end else begin
            pll_reset    <= (state_next == ST_BTN) || (state_next == ST_PLL_RST) ||
                            (state_next == ST_FAIL);
            emif_reset_n <= (state_next == ST_WAIT_CAL) || (state_next == ST_RUN);
            core_reset_n <= (state_next == ST_RUN);
            seq_fail     <= (state_next == ST_FAIL);
            seq_state    <= state_next;
        end
    end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Scoreboard bench for cpu_reset_sequencer. Stimulus pushes the expected
// output word and the cycle it must appear in. The monitor checks each entry at
// its cycle. It flags any output change that no queue entry accounts for.
// The PLL and EMIF are modelled: lock drops while pll_reset is high, and
// calibration success needs emif_reset_n to be released.

module tb_cpu_reset_sequencer;

    localparam int unsigned SYNC_DEPTH       = 2;
    localparam int unsigned DEBOUNCE_CYCLES  = 8;
    localparam int unsigned PLL_RESET_CYCLES = 4;
    localparam int unsigned LOCK_TIMEOUT     = 32;
    localparam int unsigned CAL_TIMEOUT      = 64;
    localparam int unsigned MAX_RETRIES      = 2;

    // {pll_reset, emif_reset_n, core_reset_n, seq_fail, seq_state}
    localparam logic [6:0] S_BTN  = 7'b1000_000;
    localparam logic [6:0] S_PLL  = 7'b1000_001;
    localparam logic [6:0] S_WL   = 7'b0000_010;
    localparam logic [6:0] S_WC   = 7'b0100_011;
    localparam logic [6:0] S_RUN  = 7'b0110_100;
    localparam logic [6:0] S_FAIL = 7'b1001_101;

    logic       clk           = 1'b0;
    logic       reset_n       = 1'b1;
    logic       button_n      = 1'b1;
    logic       pll_ok        = 1'b1;
    logic       cal_ok        = 1'b1;
    logic       emif_cal_fail = 1'b0;
    logic       pll_locked;
    logic       emif_cal_success;
    logic       pll_reset;
    logic       emif_reset_n;
    logic       core_reset_n;
    logic       seq_fail;
    logic [2:0] seq_state;

    assign pll_locked       = pll_ok & ~pll_reset;
    assign emif_cal_success = cal_ok & emif_reset_n;

    cpu_reset_sequencer #(
        .SYNC_DEPTH      (SYNC_DEPTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .PLL_RESET_CYCLES(PLL_RESET_CYCLES),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT),
        .CAL_TIMEOUT     (CAL_TIMEOUT),
        .MAX_RETRIES     (MAX_RETRIES)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .button_n        (button_n),
        .pll_locked      (pll_locked),
        .emif_cal_success(emif_cal_success),
        .emif_cal_fail   (emif_cal_fail),
        .pll_reset       (pll_reset),
        .emif_reset_n    (emif_reset_n),
        .core_reset_n    (core_reset_n),
        .seq_fail        (seq_fail),
        .seq_state       (seq_state)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues: expected cycle, expected output word, check name.
    int unsigned q_cyc[$];
    logic [6:0]  q_val[$];
    string       q_name[$];

    int          n_checks  = 0;
    int          n_fail    = 0;
    logic [6:0]  prev      = '0;
    bit          have_prev = 1'b0;
    wire  [6:0]  obs = {pll_reset, emif_reset_n, core_reset_n, seq_fail, seq_state};

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (q_cyc.size() != 0 && q_cyc[0] < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected %b at cycle %0d, never checked (now cycle %0d)",
                     q_name[0], q_val[0], q_cyc[0], cyc);
            void'(q_cyc.pop_front());
            void'(q_val.pop_front());
            void'(q_name.pop_front());
        end
        if (q_cyc.size() != 0 && q_cyc[0] == cyc) begin
            n_checks++;
            if (obs !== q_val[0]) begin
                n_fail++;
                $display("FAIL %s: cycle %0d outputs %b, expected %b",
                         q_name[0], cyc, obs, q_val[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_val.pop_front());
            void'(q_name.pop_front());
        end else if (have_prev && obs !== prev) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_change: cycle %0d outputs %b -> %b, expected no change",
                     cyc, prev, obs);
        end
        prev      = obs;
        have_prev = 1'b1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned c, input logic [6:0] v, input string name);
        q_cyc.push_back(c);
        q_val.push_back(v);
        q_name.push_back(name);
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (q_cyc.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (q_cyc.size() != 0) begin
            $display("FAIL drain_timeout: %0d expected events pending, required 0", q_cyc.size());
            $fatal(1, "scoreboard stalled");
        end
    endtask

    // Bring-up from PLL_RST entry at cycle p: 4 cycles of PLL reset, then
    // 2 sync + 1 register for lock, then the same for calibration.
    task automatic expect_bringup(input int unsigned p, input string tag, input bit to_run);
        expect_at(p + 4, S_WL, {tag, "_wait_lock"});
        expect_at(p + 7, S_WC, {tag, "_wait_cal"});
        if (to_run) expect_at(p + 10, S_RUN, {tag, "_run"});
    endtask

    task automatic lock_glitch(output int unsigned n);
        step();
        n = cyc;
        pll_ok = 1'b0;
        step();
        pll_ok = 1'b1;
    endtask

    // Press then release; ends back in RUN with the current pll_ok/cal_ok.
    task automatic press_release(input string tag);
        int unsigned n;
        step();
        n = cyc;
        button_n = 1'b0;
        expect_at(n + 10, S_BTN, {tag, "_press_btn"});
        drain();
        step();
        n = cyc;
        button_n = 1'b1;
        expect_at(n + 10, S_PLL, {tag, "_release_pll_rst"});
        expect_bringup(n + 10, tag, 1'b1);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned c;

        // 1. reset state, nominal bring-up
        #2 reset_n = 1'b0;
        repeat (2) step();
        expect_at(cyc + 1, S_PLL, "reset_state");
        drain();
        step();
        n = cyc;
        reset_n = 1'b1;
        expect_bringup(n, "t1", 1'b1);
        drain();

        // 2. bounce ignored, then a held press and a release
        step();
        n = cyc;
        expect_at(n + 55, S_RUN, "t2_bounce_stays_run");
        for (int i = 0; i < 16; i++) begin
            button_n = ~button_n;
            repeat (3) step();
        end
        drain();
        press_release("t2");

        // 3. lock never comes back: two timed-out attempts, then FAIL
        step();
        n = cyc;
        pll_ok = 1'b0;
        expect_at(n + 3,    S_PLL,  "t3_lockloss_pll_rst");
        expect_at(n + 7,    S_WL,   "t3_try1_wait_lock");
        expect_at(n + 39,   S_PLL,  "t3_try1_timeout");
        expect_at(n + 43,   S_WL,   "t3_try2_wait_lock");
        expect_at(n + 75,   S_FAIL, "t3_fail");
        expect_at(n + 1075, S_FAIL, "t3_fail_hold");
        drain();
        step();
        n = cyc;
        button_n = 1'b0;
        expect_at(n + 10, S_BTN, "t3_press_clears_fail");
        drain();
        pll_ok = 1'b1;
        step();
        n = cyc;
        button_n = 1'b1;
        expect_at(n + 10, S_PLL, "t3_restart_pll_rst");
        expect_bringup(n + 10, "t3_restart", 1'b1);
        drain();

        // 4a. calibration fail pulse retries, second attempt succeeds
        cal_ok = 1'b0;
        lock_glitch(n);
        expect_at(n + 3, S_PLL, "t4a_pll_rst");
        expect_bringup(n + 3, "t4a", 1'b0);
        drain();
        step();
        c = cyc;
        emif_cal_fail = 1'b1;
        expect_at(c + 3, S_PLL, "t4a_calfail_retry");
        step();
        emif_cal_fail = 1'b0;
        drain();
        cal_ok = 1'b1;
        expect_bringup(c + 3, "t4a_try2", 1'b1);
        drain();

        // 4b. simultaneous fail+success counts as a retry; next fail exhausts
        cal_ok = 1'b0;
        lock_glitch(n);
        expect_at(n + 3, S_PLL, "t4b_pll_rst");
        expect_bringup(n + 3, "t4b", 1'b0);
        drain();
        step();
        c = cyc;
        emif_cal_fail = 1'b1;
        cal_ok = 1'b1;
        expect_at(c + 3, S_PLL, "t4b_both_is_fail");
        step();
        emif_cal_fail = 1'b0;
        cal_ok = 1'b0;
        drain();
        expect_bringup(c + 3, "t4b_try2", 1'b0);
        drain();
        step();
        c = cyc;
        emif_cal_fail = 1'b1;
        expect_at(c + 3, S_FAIL, "t4b_retries_exhausted");
        step();
        emif_cal_fail = 1'b0;
        drain();
        cal_ok = 1'b1;
        press_release("t4b_recover");

        // 5. three consecutive lock losses in RUN never reach FAIL
        for (int k = 0; k < 3; k++) begin
            lock_glitch(n);
            expect_at(n + 3, S_PLL, "t5_lockloss_pll_rst");
            expect_bringup(n + 3, "t5", 1'b1);
            drain();
        end

        // 6. asynchronous reset in WAIT_CAL, then restart
        cal_ok = 1'b0;
        lock_glitch(n);
        expect_at(n + 3, S_PLL, "t6_pll_rst");
        expect_bringup(n + 3, "t6", 1'b0);
        drain();
        repeat (2) step();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        expect_at(cyc, S_PLL, "t6_async_reset_immediate");
        drain();
        repeat (2) step();
        step();
        n = cyc;
        cal_ok = 1'b1;
        reset_n = 1'b1;
        expect_bringup(n, "t6_restart", 1'b1);
        drain();

        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
